// File: rtl/wb_arb_pkg.sv
// wb_arbiter shared types and helpers.
// Imported by the arbiter top and its round-robin picker.
package wb_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_t;

  // Index width that stays >= 1 even for tiny counts.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Combinational round-robin picker.
// Searches last+1, last+2, ... modulo NUM_CTRL for the first requester.
module wb_arb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int NUM_CTRL = 2,
  parameter int IW       = idx_w(NUM_CTRL)
) (
  input  logic [NUM_CTRL-1:0] req_i,
  input  logic [IW-1:0]       last_i,
  output logic                valid_o,
  output logic [IW-1:0]       pick_o
);

  int idx;

  // First requester after the previous winner wins.
  always_comb begin
    valid_o = 1'b0;
    pick_o  = '0;
    idx     = 0;
    for (int i = 1; i <= NUM_CTRL; i++) begin
      idx = (int'(last_i) + i) % NUM_CTRL;
      if (!valid_o && req_i[idx]) begin
        valid_o = 1'b1;
        pick_o  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin cycle-level Wishbone arbiter, NUM_CTRL controllers to one device.
// Optional watchdog release when WB_ARB_TIMEOUT_EN is defined.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_CTRL       = 2,
  parameter int DATA_WIDTH     = 8
`ifdef WB_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_CTRL-1:0]            ctrl_cyc_i,
  input  logic [NUM_CTRL-1:0]            ctrl_stb_i,
  input  logic [NUM_CTRL-1:0]            ctrl_we_i,
  input  logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_dat_i,
  output logic [NUM_CTRL-1:0]            ctrl_ack_o,
  output logic [NUM_CTRL-1:0]            ctrl_stall_o,
  output logic [DATA_WIDTH-1:0]          ctrl_dat_o,
`ifdef WB_ARB_TIMEOUT_EN
  output logic [NUM_CTRL-1:0]            ctrl_err_o,
`endif
  output logic                           dev_cyc_o,
  output logic                           dev_stb_o,
  output logic                           dev_we_o,
  output logic [DATA_WIDTH-1:0]          dev_dat_o,
  input  logic [DATA_WIDTH-1:0]          dev_dat_i,
  input  logic                           dev_ack_i,
  input  logic                           dev_stall_i,
  output logic [NUM_CTRL-1:0]            grant_o
);

  localparam int IW = idx_w(NUM_CTRL);

  state_t                state_q, state_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic [IW-1:0]         last_q, last_d;
  logic [NUM_CTRL-1:0]   grant_q, grant_d;

  logic                  own_cyc, own_stb, own_we;
  logic [DATA_WIDTH-1:0] own_dat;
  logic                  active;
  logic                  to_hit;
  logic [NUM_CTRL-1:0]   req;
  logic                  pick_vld;
  logic [IW-1:0]         pick;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WW-1:0]         wd_q, wd_d;
  logic [NUM_CTRL-1:0]   err_q, err_d;
  logic [NUM_CTRL-1:0]   blk_q, blk_d;
  logic                  busy;

  assign to_hit     = (state_q == GRANTED) &&
                      (wd_q == WW'(TIMEOUT_CYCLES));
  assign req        = ctrl_cyc_i & ~blk_q;
  assign ctrl_err_o = err_q;
  assign busy       = (dev_stb_o && !dev_stall_i) || dev_ack_i;
`else
  assign to_hit = 1'b0;
  assign req    = ctrl_cyc_i;
`endif

  wb_arb_rr_pick #(
    .NUM_CTRL (NUM_CTRL),
    .IW       (IW)
  ) u_pick (
    .req_i   (req),
    .last_i  (last_q),
    .valid_o (pick_vld),
    .pick_o  (pick)
  );

  assign grant_o    = grant_q & {NUM_CTRL{~rst_i}};
  assign ctrl_dat_o = dev_dat_i;

  // Owner mux and per-controller ack/stall routing.
  always_comb begin
    own_cyc   = ctrl_cyc_i[owner_q];
    own_stb   = ctrl_stb_i[owner_q];
    own_we    = ctrl_we_i[owner_q];
    own_dat   = ctrl_dat_i[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
    active    = (state_q == GRANTED) && !rst_i &&
                !to_hit && own_cyc;
    dev_cyc_o = active;
    dev_stb_o = active && own_stb;
    dev_we_o  = active && own_we;
    dev_dat_o = active ? own_dat : '0;
    for (int k = 0; k < NUM_CTRL; k++) begin
      if (active && (int'(owner_q) == k)) begin
        ctrl_ack_o[k]   = dev_ack_i;
        ctrl_stall_o[k] = dev_stall_i;
      end else begin
        ctrl_ack_o[k]   = 1'b0;
        ctrl_stall_o[k] = ctrl_cyc_i[k] && ctrl_stb_i[k];
      end
    end
  end

  // Next-state: grant on request, release on cyc drop or watchdog.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d       = GRANTED;
          owner_d       = pick;
          last_d        = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
        end
      end
      GRANTED: begin
        if (!own_cyc || to_hit) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  // Watchdog: count idle owned cycles, flag and block on expiry.
  always_comb begin
    wd_d  = '0;
    err_d = '0;
    blk_d = blk_q & ctrl_cyc_i;
    if (state_q == GRANTED && !to_hit && own_cyc) begin
      wd_d = busy ? '0 : wd_q + 1'b1;
      if (!busy && wd_q == WW'(TIMEOUT_CYCLES - 1))
        err_d[owner_q] = 1'b1;
    end
    if (to_hit)
      blk_d[owner_q] = 1'b1;
  end

  // Watchdog registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_q  <= '0;
      err_q <= '0;
      blk_q <= '0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
      blk_q <= blk_d;
    end
  end
`endif

  // Arbiter state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(NUM_CTRL - 1);
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter.
// Runs the watchdog scenario only when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cyc, stb, we;
  logic [15:0] dat;
  logic [1:0]  ack, stall, err;
  logic [7:0]  cdat;
  logic        dcyc, dstb, dwe;
  logic [7:0]  ddat, ddat_i;
  logic        dack, dstall;
  logic [1:0]  grant;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_arbiter #(
    .NUM_CTRL       (2),
    .DATA_WIDTH     (8)
`ifdef WB_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (8)
`endif
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .ctrl_cyc_i   (cyc),
    .ctrl_stb_i   (stb),
    .ctrl_we_i    (we),
    .ctrl_dat_i   (dat),
    .ctrl_ack_o   (ack),
    .ctrl_stall_o (stall),
    .ctrl_dat_o   (cdat),
`ifdef WB_ARB_TIMEOUT_EN
    .ctrl_err_o   (err),
`endif
    .dev_cyc_o    (dcyc),
    .dev_stb_o    (dstb),
    .dev_we_o     (dwe),
    .dev_dat_o    (ddat),
    .dev_dat_i    (ddat_i),
    .dev_ack_i    (dack),
    .dev_stall_i  (dstall),
    .grant_o      (grant)
  );

`ifndef WB_ARB_TIMEOUT_EN
  assign err = 2'b00;
`endif

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  bit [7:0] stall_v = 8'b0000_1110;
  bit [7:0] stb_v   = 8'b0111_1111;
  bit [7:0] ack_v   = 8'b1110_0010;
  int       di [8]  = '{0, 1, 1, 1, 1, 2, 3, 3};
  int       acks;
  int       e;

  initial begin
    rst = 1'b1; cyc = 0; stb = 0; we = 0; dat = 0;
    ddat_i = 8'h5A; dack = 0; dstall = 0;
    step();
    step();
    cyc = 2'b10; stb = 2'b10;
    settle();
    chk("rst_grant", grant, 0);
    chk("rst_dcyc", dcyc, 0);
    chk("rst_dstb", dstb, 0);
    chk("rst_ack", ack, 0);
    chk("rst_stall", stall, 2'b10);
    chk("rst_err", err, 0);
    chk("rst_cdat", cdat, 8'h5A);
    cyc = 0; stb = 0; rst = 0;
    step();

    // single controller transfer
    cyc = 2'b01; stb = 2'b01; we = 2'b01; dat = 16'h00A5;
    settle();
    chk("t1_idle_grant", grant, 0);
    chk("t1_idle_dcyc", dcyc, 0);
    chk("t1_idle_stall", stall, 2'b01);
    step();
    chk("t1_grant", grant, 2'b01);
    chk("t1_dcyc", dcyc, 1);
    chk("t1_dstb", dstb, 1);
    chk("t1_dwe", dwe, 1);
    chk("t1_ddat", ddat, 8'hA5);
    dack = 1;
    settle();
    chk("t1_ack", ack, 2'b01);
    dack = 0;
    settle();
    chk("t1_ack0", ack, 0);
    cyc = 0; stb = 0;
    settle();
    chk("t1_rel_dcyc", dcyc, 0);
    dack = 1;
    settle();
    chk("t1_late_ack", ack, 0);
    dack = 0;
    step();
    chk("t1_idle", grant, 0);

    // simultaneous request from reset
    do_reset();
    cyc = 2'b11; stb = 2'b11; dat = 16'h3CA5;
    settle();
    chk("t2_idle", grant, 0);
    step();
    chk("t2_grant0", grant, 2'b01);
    chk("t2_stall", stall, 2'b10);
    chk("t2_ddat0", ddat, 8'hA5);
    cyc[0] = 0; stb[0] = 0;
    settle();
    chk("t2_rel_dcyc", dcyc, 0);
    step();
    chk("t2_gap_grant", grant, 0);
    chk("t2_gap_dcyc", dcyc, 0);
    step();
    chk("t2_grant1", grant, 2'b10);
    chk("t2_ddat1", ddat, 8'h3C);

    // alternation under continuous demand
    cyc = 0; stb = 0;
    do_reset();
    cyc = 2'b11; stb = 2'b11;
    for (int k = 0; k < 4; k++) begin
      e = k % 2;
      step();
      chk("t3_grant", grant, 32'(1 << e));
      dack = 1;
      settle();
      chk("t3_ack", ack, 32'(1 << e));
      step();
      dack = 0;
      cyc[e] = 0; stb[e] = 0;
      settle();
      chk("t3_rel_dcyc", dcyc, 0);
      step();
      chk("t3_gap", grant, 0);
      cyc[e] = 1; stb[e] = 1;
    end

    // pipelined burst with device stall
    cyc = 0; stb = 0;
    do_reset();
    cyc = 2'b01;
    step();
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      stb[0]  = stb_v[c];
      dat     = 16'(8'h10 + di[c]);
      dstall  = stall_v[c];
      dack    = ack_v[c];
      settle();
      chk("t4_stall", stall[0], stall_v[c]);
      chk("t4_grant", grant, 2'b01);
      if (stb_v[c])
        chk("t4_ddat", ddat, 32'(8'h10 + di[c]));
      acks += int'(ack[0]);
      step();
    end
    dack = 0; dstall = 0;
    chk("t4_acks", acks, 4);
    cyc = 0; stb = 0;
    step();

    // reset during an owned cycle
    do_reset();
    cyc = 2'b01; stb = 2'b01;
    step();
    chk("t5_grant", grant, 2'b01);
    rst = 1;
    settle();
    chk("t5_dcyc", dcyc, 0);
    chk("t5_dstb", dstb, 0);
    chk("t5_grant_rst", grant, 0);
    step();
    rst = 0;
    cyc = 2'b11; stb = 2'b11;
    settle();
    chk("t5_idle", grant, 0);
    step();
    chk("t5_regrant", grant, 2'b01);

`ifdef WB_ARB_TIMEOUT_EN
    // watchdog release
    cyc = 0; stb = 0;
    do_reset();
    chk("t6_err_rst", err, 0);
    cyc = 2'b11; stb = 2'b00;
    step();
    chk("t6_grant", grant, 2'b01);
    for (int i = 0; i < 8; i++) begin
      chk("t6_err_pre", err, 0);
      chk("t6_dcyc_pre", dcyc, 1);
      step();
    end
    chk("t6_err", err, 2'b01);
    chk("t6_dcyc", dcyc, 0);
    step();
    chk("t6_idle", grant, 0);
    chk("t6_err_off", err, 0);
    step();
    chk("t6_next", grant, 2'b10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
